tx_serializer: RTL and testbench
================================

# tx_serializer

Downstream transmit stage of the memory read path: when the RW flow controller raises `TxData`, this block captures the word read from memory and shifts it out on a single serial line as a framed character. The frame is a start bit, the data LSB first, optional even parity, and a stop bit. It reports completion to the controller with a one-cycle `TxDone` pulse, which is what lets the controller leave its transmit state. `TxBusy` covers the whole transmission.

## Interface
- `DATA_WIDTH`, 8, width of the memory word that is serialized (≥1).
- `CLKS_PER_BIT`, 4, clock cycles each serial bit is held (≥1).
- `PARITY_EN`, 1, 1 = insert an even-parity bit after the data; 0 = no parity bit.

- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-low reset (0 = reset asserted).
- `TxData` input 1: transmit request from the RW flow controller; the rising edge starts a frame.
- `DataIn` input DATA_WIDTH: memory read word; sampled only on the start edge.
- `SerialOut` output 1: serial line; idles high.
- `TxBusy` output 1: high while a frame is in progress, including the done cycle.
- `TxDone` output 1: one-cycle pulse after the stop bit completes.

## Operation
- Request detect:
  - `TxData_q` registers `TxData` every cycle.
  - Start condition is `TxData & ~TxData_q` while state = IDLE.
  - A rising edge while not IDLE is ignored and is not queued.
  - A level held high after a frame does not retrigger; `TxData` must go low and then high again.
- On start: load `DataIn` into the shift register, compute parity = XOR of all data bits, clear the bit-cycle counter, and enter START.
- States and `SerialOut` value in each:
  - IDLE: `SerialOut`=1.
  - START: `SerialOut`=0.
  - DATA: `SerialOut`=shift[0]; the register shifts right once per bit, DATA_WIDTH bits, LSB first.
  - PARITY: `SerialOut`=parity. Entered only if PARITY_EN=1; otherwise DATA goes directly to STOP.
  - STOP: `SerialOut`=1.
  - DONE: `SerialOut`=1, `TxDone`=1 for exactly one cycle, then IDLE.
- Bit timing:
  - Each of START/DATA-bit/PARITY/STOP lasts exactly CLKS_PER_BIT cycles.
  - The counter counts 0..CLKS_PER_BIT-1 and the bit advances when it reaches CLKS_PER_BIT-1.
  - Counter width is clog2(CLKS_PER_BIT), minimum 1 bit.
  - The data bit index counts 0..DATA_WIDTH-1 and wraps to 0 on leaving DATA.
- `TxBusy` = (state ≠ IDLE).
- `SerialOut` is registered and must not glitch between bits.

## Timing
- Reset (async, `Reset`=0), all immediate:
  - state=IDLE, `SerialOut`=1, `TxBusy`=0, `TxDone`=0.
  - shift register=0, counters=0, `TxData_q`=0.
- Reset mid-frame aborts the frame immediately: the line returns high and no `TxDone` is produced.
- If `TxData` is already high when reset deasserts, the first rising `Clk` edge sees an edge (`TxData_q`=0) and starts a frame.
- Start latency: on the rising edge where the start condition is true, state becomes START and `SerialOut` goes 0 after that edge.
- Frame length F = (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles. `TxDone` is high in cycle F+1 after the start edge, and `TxBusy` drops after that cycle.
- With the defaults (8/4/1): F = 44, `TxDone` in cycle 45, ready for the next start edge at cycle 46.
- `DataIn` changes after the start edge do not affect the frame in progress.

## Test plan
- Reset values: hold `Reset`=0 with `TxData`=1 and `DataIn`=8'hFF.
  - While reset is held: `SerialOut`=1, `TxBusy`=0, `TxDone`=0.
  - Release reset: a frame starts on the first edge.
- Basic frame (defaults): `DataIn`=8'hA5, pulse `TxData` high.
  - Line sequence, each bit 4 cycles: 0,1,0,1,0,0,1,0,1, parity 0, stop 1.
  - `TxDone` is a single pulse in cycle 45.
- Parity odd data with PARITY_EN=1: `DataIn`=8'h07 gives parity bit 1.
  - Rerun with PARITY_EN=0: frame is 40 cycles and `TxDone` is in cycle 41.
- Held/retrigger requests:
  - Hold `TxData` high through and past `TxDone`: no second frame.
  - Pulse `TxData` again mid-frame (low then high): ignored, `TxBusy` unchanged, exactly one `TxDone`.
- Reset mid-frame: assert `Reset`=0 during data bit 3.
  - `SerialOut`=1 and `TxBusy`=0 immediately, with no `TxDone`.
  - A new request after release transmits a correct full frame.
- CLKS_PER_BIT=1, `DataIn`=8'h01:
  - Line is 0,1,0,0,0,0,0,0,0,1(parity),1(stop), one cycle each.
  - `TxDone` is in cycle 12.

Source files
------------

// File: rtl/tx_serializer.sv
// Framed serial transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional even parity, stop bit, then a one-cycle completion pulse.
module tx_serializer #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  TxData,
   input  logic [DATA_WIDTH-1:0] DataIn,
   output logic                  SerialOut,
   output logic                  TxBusy,
   output logic                  TxDone
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE
   } state_t;

   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [IW-1:0]         idx, idx_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic                  parity, parity_n;
   logic                  txdata_q;
   logic                  serial_q, serial_n;
   logic                  start;
   logic                  bit_end;

   assign start   = TxData & ~txdata_q & (state == S_IDLE);
   assign bit_end = (cnt == CNT_LAST);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      shift_n  = shift;
      parity_n = parity;
      case (state)
         S_IDLE: begin
            if (start) begin
               shift_n  = DataIn;
               parity_n = ^DataIn;
               cnt_n    = '0;
               idx_n    = '0;
               state_n  = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = S_DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_n   = '0;
               shift_n = shift >> 1;
               if (idx == IDX_LAST) begin
                  idx_n   = '0;
                  state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = S_STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = S_DONE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_DONE: begin
            cnt_n   = '0;
            state_n = S_IDLE;
         end
         default: begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = S_IDLE;
         end
      endcase
   end

   // Line value is decoded from the next state so the output flop changes
   // on the same edge as the state, keeping SerialOut glitch-free.
   always_comb begin
      serial_n = 1'b1;
      case (state_n)
         S_START:  serial_n = 1'b0;
         S_DATA:   serial_n = shift_n[0];
         S_PARITY: serial_n = parity_n;
         default:  serial_n = 1'b1;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         shift    <= '0;
         parity   <= 1'b0;
         txdata_q <= 1'b0;
         serial_q <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         shift    <= shift_n;
         parity   <= parity_n;
         txdata_q <= TxData;
         serial_q <= serial_n;
      end
   end

   assign SerialOut = serial_q;
   assign TxBusy    = (state != S_IDLE);
   assign TxDone    = (state == S_DONE);

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: three instances cover the default,
// no-parity and one-clock-per-bit configurations.
module tb_tx_serializer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tx0, tx1, tx2;
   logic [7:0] d0, d1, d2;
   logic s0, b0, k0, s1, b1, k1, s2, b2, k2;

   int total = 0;
   int bad = 0;

   logic cs [0:63];
   logic cb [0:63];
   logic cd [0:63];

   always #5 clk = ~clk;

   tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_def (
      .Clk(clk), .Reset(rst_n), .TxData(tx0), .DataIn(d0),
      .SerialOut(s0), .TxBusy(b0), .TxDone(k0));

   tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_nopar (
      .Clk(clk), .Reset(rst_n), .TxData(tx1), .DataIn(d1),
      .SerialOut(s1), .TxBusy(b1), .TxDone(k1));

   tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_fast (
      .Clk(clk), .Reset(rst_n), .TxData(tx2), .DataIn(d2),
      .SerialOut(s2), .TxBusy(b2), .TxDone(k2));

   // Expected line value in cycle k (1-based) after the start edge.
   function automatic logic exp_line(input logic [7:0] d, input int cpb,
                                     input int pe, input int k);
      int i;
      i = (k - 1) / cpb;
      if (i == 0) return 1'b0;
      if (i <= 8) return d[i-1];
      if (i == 9 && pe != 0) return ^d;
      return 1'b1;
   endfunction

   task automatic set_tx(input int sel, input logic v);
      case (sel)
         0: tx0 = v;
         1: tx1 = v;
         default: tx2 = v;
      endcase
   endtask

   // Raise TxData before the next edge (edge 0) and record cycles 1..n.
   task automatic capture(input int sel, input int n, input int drop_at,
                          input int pulse_at);
      @(negedge clk);
      set_tx(sel, 1'b1);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         case (sel)
            0: begin cs[k] = s0; cb[k] = b0; cd[k] = k0; end
            1: begin cs[k] = s1; cb[k] = b1; cd[k] = k1; end
            default: begin cs[k] = s2; cb[k] = b2; cd[k] = k2; end
         endcase
         if (k == drop_at) set_tx(sel, 1'b0);
         if (pulse_at != 0 && k == pulse_at) set_tx(sel, 1'b1);
         if (pulse_at != 0 && k == pulse_at + 2) set_tx(sel, 1'b0);
      end
   endtask

   task automatic test_reset;
      int cyc;
      tx0 = 1'b1; d0 = 8'hFF;
      tx1 = 1'b0; d1 = 8'h00;
      tx2 = 1'b0; d2 = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (s0 !== 1'b1) begin bad++; $display("FAIL reset_serial got=%b exp=1", s0); end
      total++; if (b0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", b0); end
      total++; if (k0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", k0); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (s0 !== 1'b0 || b0 !== 1'b1)
         begin bad++; $display("FAIL reset_release_start got=%b%b exp=01", s0, b0); end
      cyc = 1;
      while (k0 !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      total++; if (cyc != 45) begin bad++; $display("FAIL reset_release_done_cycle got=%0d exp=45", cyc); end
      tx0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int nd;
      d0 = 8'hA5;
      capture(0, 47, 2, 0);
      for (int k = 1; k <= 44; k++) begin
         total++;
         if (cs[k] !== exp_line(8'hA5, 4, 1, k)) begin
            bad++; $display("FAIL basic_line cycle=%0d got=%b exp=%b", k, cs[k], exp_line(8'hA5, 4, 1, k));
         end
      end
      total++; if (cs[40] !== 1'b0) begin bad++; $display("FAIL basic_parity got=%b exp=0", cs[40]); end
      nd = 0;
      for (int k = 1; k <= 47; k++) if (cd[k] === 1'b1) nd++;
      total++; if (nd != 1 || cd[45] !== 1'b1)
         begin bad++; $display("FAIL basic_done pulses=%0d at45=%b exp=1,1", nd, cd[45]); end
      total++; if (cs[45] !== 1'b1) begin bad++; $display("FAIL basic_done_line got=%b exp=1", cs[45]); end
      total++; if (cb[1] !== 1'b1 || cb[45] !== 1'b1 || cb[46] !== 1'b0)
         begin bad++; $display("FAIL basic_busy got=%b%b%b exp=110", cb[1], cb[45], cb[46]); end
   endtask

   task automatic test_parity;
      int nd;
      d0 = 8'h07;
      capture(0, 47, 2, 0);
      for (int k = 37; k <= 40; k++) begin
         total++;
         if (cs[k] !== 1'b1) begin bad++; $display("FAIL parity_odd cycle=%0d got=%b exp=1", k, cs[k]); end
      end
      total++; if (cd[45] !== 1'b1) begin bad++; $display("FAIL parity_odd_done got=%b exp=1", cd[45]); end
      d1 = 8'h07;
      capture(1, 43, 2, 0);
      for (int k = 1; k <= 40; k++) begin
         total++;
         if (cs[k] !== exp_line(8'h07, 4, 0, k)) begin
            bad++; $display("FAIL nopar_line cycle=%0d got=%b exp=%b", k, cs[k], exp_line(8'h07, 4, 0, k));
         end
      end
      nd = 0;
      for (int k = 1; k <= 43; k++) if (cd[k] === 1'b1) nd++;
      total++; if (nd != 1 || cd[41] !== 1'b1)
         begin bad++; $display("FAIL nopar_done pulses=%0d at41=%b exp=1,1", nd, cd[41]); end
      total++; if (cb[41] !== 1'b1 || cb[42] !== 1'b0)
         begin bad++; $display("FAIL nopar_busy got=%b%b exp=10", cb[41], cb[42]); end
   endtask

   task automatic test_held;
      int nd;
      d0 = 8'h3C;
      capture(0, 60, 0, 0);
      nd = 0;
      for (int k = 1; k <= 60; k++) if (cd[k] === 1'b1) nd++;
      total++; if (nd != 1 || cd[45] !== 1'b1)
         begin bad++; $display("FAIL held_done pulses=%0d at45=%b exp=1,1", nd, cd[45]); end
      for (int k = 46; k <= 60; k++) begin
         total++;
         if (cb[k] !== 1'b0 || cs[k] !== 1'b1) begin
            bad++; $display("FAIL held_retrigger cycle=%0d busy=%b line=%b exp=0,1", k, cb[k], cs[k]);
         end
      end
      tx0 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_retrigger;
      int nd;
      d0 = 8'h5A;
      capture(0, 52, 2, 10);
      for (int k = 1; k <= 44; k++) begin
         total++;
         if (cs[k] !== exp_line(8'h5A, 4, 1, k) || cb[k] !== 1'b1) begin
            bad++; $display("FAIL retrig_line cycle=%0d line=%b busy=%b exp=%b,1", k, cs[k], cb[k], exp_line(8'h5A, 4, 1, k));
         end
      end
      nd = 0;
      for (int k = 1; k <= 52; k++) if (cd[k] === 1'b1) nd++;
      total++; if (nd != 1 || cd[45] !== 1'b1)
         begin bad++; $display("FAIL retrig_done pulses=%0d at45=%b exp=1,1", nd, cd[45]); end
      total++; if (cb[46] !== 1'b0 || cb[52] !== 1'b0)
         begin bad++; $display("FAIL retrig_busy_after got=%b%b exp=00", cb[46], cb[52]); end
   endtask

   task automatic test_reset_mid;
      int nd;
      d0 = 8'hA5;
      @(negedge clk);
      tx0 = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 2) tx0 = 1'b0;
      end
      total++; if (s0 !== 1'b0 || b0 !== 1'b1)
         begin bad++; $display("FAIL midrst_before line=%b busy=%b exp=0,1", s0, b0); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (s0 !== 1'b1 || b0 !== 1'b0 || k0 !== 1'b0)
         begin bad++; $display("FAIL midrst_abort line=%b busy=%b done=%b exp=1,0,0", s0, b0, k0); end
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k0 === 1'b1 || b0 === 1'b1) nd++;
      end
      total++; if (nd != 0) begin bad++; $display("FAIL midrst_quiet got=%0d exp=0", nd); end
      capture(0, 46, 2, 0);
      for (int k = 1; k <= 44; k++) begin
         total++;
         if (cs[k] !== exp_line(8'hA5, 4, 1, k)) begin
            bad++; $display("FAIL midrst_reframe cycle=%0d got=%b exp=%b", k, cs[k], exp_line(8'hA5, 4, 1, k));
         end
      end
      total++; if (cd[45] !== 1'b1) begin bad++; $display("FAIL midrst_reframe_done got=%b exp=1", cd[45]); end
   endtask

   task automatic test_cpb1;
      logic [10:0] want;
      int nd;
      want = 11'b11_0000_0001_0; // bit k-1 is the line in cycle k
      d2 = 8'h01;
      capture(2, 14, 2, 0);
      for (int k = 1; k <= 11; k++) begin
         total++;
         if (cs[k] !== want[k-1]) begin
            bad++; $display("FAIL cpb1_line cycle=%0d got=%b exp=%b", k, cs[k], want[k-1]);
         end
      end
      nd = 0;
      for (int k = 1; k <= 14; k++) if (cd[k] === 1'b1) nd++;
      total++; if (nd != 1 || cd[12] !== 1'b1)
         begin bad++; $display("FAIL cpb1_done pulses=%0d at12=%b exp=1,1", nd, cd[12]); end
      total++; if (cb[12] !== 1'b1 || cb[13] !== 1'b0)
         begin bad++; $display("FAIL cpb1_busy got=%b%b exp=10", cb[12], cb[13]); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_parity;
      test_held;
      test_retrigger;
      test_reset_mid;
      test_cpb1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
